// File: rtl/mac_acc_v3_if.sv
// mac_acc_v3_if: sample/result bus for the framed MAC engine
interface mac_acc_v3_if #(
    parameter int AW   = 27,
    parameter int BW   = 18,
    parameter int PW   = 48,
    parameter int CNTW = 16
);
    logic                   in_valid;
    logic                   sload;
    logic                   last;
    logic [1:0]             mode;
    logic signed [AW-1:0]   ain;
    logic signed [BW-1:0]   bin;
    logic signed [PW-1:0]   pout;
    logic                   res_valid;
    logic signed [PW-1:0]   res;
    logic [CNTW-1:0]        res_cnt;
    logic                   ovf;

    modport master (
        output in_valid, sload, last, mode, ain, bin,
        input  pout, res_valid, res, res_cnt, ovf
    );

    modport slave (
        input  in_valid, sload, last, mode, ain, bin,
        output pout, res_valid, res, res_cnt, ovf
    );
endinterface

// File: rtl/mac_acc_v3.sv
// mac_acc_v3: 3-stage framed signed MAC; define MAC_ACC_SAT_EN to clamp on overflow instead of wrapping
module mac_acc_v3 #(
    parameter int AW   = 27,
    parameter int BW   = 18,
    parameter int PW   = 48,
    parameter int CNTW = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    mac_acc_v3_if.slave  bus
);
    localparam int MW = AW + BW;
    localparam logic [PW-1:0]   MAXV = {1'b0, {(PW-1){1'b1}}};
    localparam logic [PW-1:0]   MINV = {1'b1, {(PW-1){1'b0}}};
    localparam logic [CNTW-1:0] CMAX = '1;

    if (PW < MW) begin : g_pw_chk
        $error("mac_acc_v3: PW must be at least AW+BW");
    end

    logic                   r_v1, r_sl1, r_last1;
    logic [1:0]             r_mode1;
    logic signed [AW-1:0]   r_a1;
    logic signed [BW-1:0]   r_b1;
    logic                   r_v2, r_sl2, r_last2;
    logic [1:0]             r_mode2;
    logic signed [PW-1:0]   r_p2;
    logic signed [PW-1:0]   r_acc;
    logic [CNTW-1:0]        r_cnt;
    logic                   r_sticky;
    logic                   r_res_valid;
    logic signed [PW-1:0]   r_res;
    logic [CNTW-1:0]        r_res_cnt;
    logic                   r_ovf;

    logic signed [MW-1:0]   w_prod;
    logic signed [PW:0]     w_base_x;
    logic signed [PW:0]     w_p_x;
    logic signed [PW:0]     w_wide;
    logic                   w_of;
    logic signed [PW-1:0]   w_new;
    logic [CNTW-1:0]        w_cnt;
    logic                   w_sticky;

    // Stage 1: capture the qualified sample
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_v1    <= 1'b0;
            r_sl1   <= 1'b0;
            r_last1 <= 1'b0;
            r_mode1 <= '0;
            r_a1    <= '0;
            r_b1    <= '0;
        end else begin
            r_v1    <= bus.in_valid;
            r_sl1   <= bus.sload;
            r_last1 <= bus.last;
            r_mode1 <= bus.mode;
            r_a1    <= bus.ain;
            r_b1    <= bus.bin;
        end
    end

    // Full-width signed product; operands widened first so no bits are lost
    always_comb w_prod = MW'(r_a1) * MW'(r_b1);

    // Stage 2: register the product sign-extended to accumulator width
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_v2    <= 1'b0;
            r_sl2   <= 1'b0;
            r_last2 <= 1'b0;
            r_mode2 <= '0;
            r_p2    <= '0;
        end else begin
            r_v2    <= r_v1;
            r_sl2   <= r_sl1;
            r_last2 <= r_last1;
            r_mode2 <= r_mode1;
            r_p2    <= PW'(w_prod);
        end
    end

    // Accumulate one bit wider so signed overflow shows as a top-bit disagreement
    always_comb begin
        w_base_x = r_sl2 ? '0 : (PW+1)'(r_acc);
        w_p_x    = (PW+1)'(r_p2);
        w_wide   = r_mode2 == 2'b01 ? w_base_x - w_p_x :
                   r_mode2 == 2'b10 ? w_p_x - w_base_x : w_base_x + w_p_x;
        w_of     = w_wide[PW] != w_wide[PW-1];
`ifdef MAC_ACC_SAT_EN
        w_new    = !w_of ? w_wide[PW-1:0] : w_wide[PW] ? MINV : MAXV;
`else
        w_new    = w_wide[PW-1:0];
`endif
        w_cnt    = r_sl2 ? CNTW'(1) : r_cnt == CMAX ? r_cnt : r_cnt + 1'b1;
        w_sticky = (r_sl2 ? 1'b0 : r_sticky) | w_of;
    end

    // Stage 3: update accumulator state and emit the frame result on last
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_acc       <= '0;
            r_cnt       <= '0;
            r_sticky    <= 1'b0;
            r_res_valid <= 1'b0;
            r_res       <= '0;
            r_res_cnt   <= '0;
            r_ovf       <= 1'b0;
        end else begin
            r_res_valid <= r_v2 & r_last2;
            if (r_v2) begin
                r_acc    <= w_new;
                r_cnt    <= w_cnt;
                r_sticky <= w_sticky;
                if (r_last2) begin
                    r_res     <= w_new;
                    r_res_cnt <= w_cnt;
                    r_ovf     <= w_sticky;
                end
            end
        end
    end

    assign bus.pout      = r_acc;
    assign bus.res_valid = r_res_valid;
    assign bus.res       = r_res;
    assign bus.res_cnt   = r_res_cnt;
    assign bus.ovf       = r_ovf;
endmodule

// File: tb/tb_mac_acc_v3.sv
// tb_mac_acc_v3: scoreboard bench for mac_acc_v3 (full-size and narrow 4x4->8, CNTW=2 instances)
module tb_mac_acc_v3;
    typedef struct {
        longint res;
        int     cnt;
        bit     ovf;
        int     cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    exp_t qa[$];
    exp_t qb[$];

    mac_acc_v3_if ifa ();
    mac_acc_v3_if #(.AW(4), .BW(4), .PW(8), .CNTW(2)) ifb ();

    mac_acc_v3 u_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
    mac_acc_v3 #(.AW(4), .BW(4), .PW(8), .CNTW(2)) u_b (.clk(clk), .rst_n(rst_n), .bus(ifb));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input longint act, input longint want);
        checks++;
        if (act != want) begin
            failures++;
            $display("FAIL %s got=%0d want=%0d", nm, act, want);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (ifa.res_valid === 1'b1) begin
            if (qa.size() == 0) chk("a_unexpected_strobe", 1, 0);
            else begin
                e = qa.pop_front();
                chk("a_res", $signed(ifa.res), e.res);
                chk("a_cnt", ifa.res_cnt, e.cnt);
                chk("a_ovf", ifa.ovf, e.ovf);
                chk("a_cycle", cyc, e.cyc);
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (ifb.res_valid === 1'b1) begin
            if (qb.size() == 0) chk("b_unexpected_strobe", 1, 0);
            else begin
                e = qb.pop_front();
                chk("b_res", $signed(ifb.res), e.res);
                chk("b_cnt", ifb.res_cnt, e.cnt);
                chk("b_ovf", ifb.ovf, e.ovf);
                chk("b_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic s(input bit d, input bit sl, input bit la, input logic [1:0] m,
                     input int a, input int b,
                     input longint er = 0, input int ec = 0, input bit eo = 0);
        @(negedge clk);
        ifa.in_valid = 1'b0;
        ifb.in_valid = 1'b0;
        if (!d) begin
            ifa.in_valid = 1'b1;
            ifa.sload    = sl;
            ifa.last     = la;
            ifa.mode     = m;
            ifa.ain      = 27'(a);
            ifa.bin      = 18'(b);
            if (la) qa.push_back('{er, ec, eo, cyc + 3});
        end else begin
            ifb.in_valid = 1'b1;
            ifb.sload    = sl;
            ifb.last     = la;
            ifb.mode     = m;
            ifb.ain      = 4'(a);
            ifb.bin      = 4'(b);
            if (la) qb.push_back('{er, ec, eo, cyc + 3});
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            ifa.in_valid = 1'b0;
            ifb.in_valid = 1'b0;
        end
    endtask

    initial begin
        ifa.in_valid = 0; ifa.sload = 0; ifa.last = 0; ifa.mode = 0; ifa.ain = 0; ifa.bin = 0;
        ifb.in_valid = 0; ifb.sload = 0; ifb.last = 0; ifb.mode = 0; ifb.ain = 0; ifb.bin = 0;
        repeat (3) @(negedge clk);
        chk("rst_pout", $signed(ifa.pout), 0);
        chk("rst_res", $signed(ifa.res), 0);
        chk("rst_valid", ifa.res_valid, 0);
        chk("rst_cnt", ifa.res_cnt, 0);
        chk("rst_ovf", ifa.ovf, 0);
        chk("rst_b_pout", $signed(ifb.pout), 0);
        rst_n = 1'b1;
        // full rate frame, mode 00
        s(0, 1, 0, 0, 2, 3);
        s(0, 0, 0, 0, -4, 5);
        s(0, 1 - 1, 1, 0, 7, 1, -7, 3);
        idle(4);
        // same frame with two-cycle gaps; pout must hold across them
        s(0, 1, 0, 0, 2, 3);
        idle(4);
        chk("gap_pout1", $signed(ifa.pout), 6);
        idle(2);
        chk("gap_pout1_hold", $signed(ifa.pout), 6);
        s(0, 0, 0, 0, -4, 5);
        idle(4);
        chk("gap_pout2", $signed(ifa.pout), -14);
        s(0, 0, 1, 0, 7, 1, -7, 3);
        idle(4);
        chk("gap_pout3", $signed(ifa.pout), -7);
        // subtract modes
        s(0, 1, 0, 0, 10, 10);
        s(0, 0, 1, 1, 1, 1, 99, 2);
        s(0, 1, 0, 0, 1, 5);
        s(0, 0, 1, 2, 1, 2, -3, 2);
        idle(4);
        // single-sample frames back to back, then mode 10/11 and continuation after last
        s(0, 1, 1, 0, -3, 3, -9, 1);
        s(0, 1, 1, 0, 4, 4, 16, 1);
        s(0, 1, 1, 2, 3, 3, 9, 1);
        s(0, 1, 0, 3, 2, 2);
        s(0, 0, 1, 3, 1, 1, 5, 2);
        s(0, 0, 1, 0, 1, 1, 6, 3);
        idle(4);
        // narrow instance: overflow, ovf clear on sload, counter saturation at 3
        s(1, 1, 0, 0, 7, 7);
        s(1, 0, 0, 0, 7, 7);
`ifdef MAC_ACC_SAT_EN
        s(1, 0, 1, 0, 7, 7, 127, 3, 1);
`else
        s(1, 0, 1, 0, 7, 7, -109, 3, 1);
`endif
        s(1, 1, 1, 0, 1, 1, 1, 1, 0);
        s(1, 1, 0, 0, 1, 1);
        s(1, 0, 0, 0, 1, 1);
        s(1, 0, 0, 0, 1, 1);
        s(1, 0, 0, 0, 1, 1);
        s(1, 0, 1, 0, 1, 1, 5, 3, 0);
        idle(4);
        // reset with a sample in flight discards it
        s(0, 1, 0, 0, 5, 5);
        @(negedge clk);
        ifa.in_valid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        idle(3);
        chk("mid_rst_pout", $signed(ifa.pout), 0);
        chk("mid_rst_res", $signed(ifa.res), 0);
        chk("mid_rst_cnt", ifa.res_cnt, 0);
        s(0, 0, 1, 0, 2, 2, 4, 1);
        idle(5);
        chk("a_pending", qa.size(), 0);
        chk("b_pending", qb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mac_acc_v3.md
Name: mac_acc_v3

Overview:
Parameterised, pipelined signed multiply-accumulate engine with valid qualification, a per-sample add/subtract mode, and framed accumulations.
- Frame boundaries: sload marks the first sample of a frame, last marks the final one.
- On the final sample the block emits the result, sample count and overflow flag with a one-cycle strobe.
- Sits in DSP datapaths (FIR taps, dot products) as the next-generation replacement for the free-running MAC.

Parameters:
AW, 27, signed width of ain
BW, 18, signed width of bin
PW, 48, accumulator/result width; elaboration error if PW < AW+BW
CNTW, 16, width of sample counter res_cnt

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  reset, synchronous, active-low
in_valid  in  1  sample qualifier; all other inputs ignored when low
sload  in  1  first sample of frame (accumulator treated as 0)
last  in  1  final sample of frame; triggers result emission
mode  in  2  00 acc+p, 01 acc-p, 10 p-acc, 11 treated as 00
ain  in  AW  signed multiplicand
bin  in  BW  signed multiplier
pout  out  PW  live accumulator value
res_valid  out  1  one-cycle result strobe
res  out  PW  final frame result, held until next strobe
res_cnt  out  CNTW  samples in the emitted frame
ovf  out  1  frame overflow flag, valid with res_valid, held with res

Behaviour:
- Reset (rst_n=0 at a clk edge): all registers cleared.
  - Pipeline valids are 0.
  - pout=0, res=0, res_valid=0, res_cnt=0, ovf=0.
  - Samples in flight are discarded; no res_valid for them.
- Pipeline:
  - S1 registers valid/sload/last/mode/ain/bin.
  - S2 registers product p = ain*bin (MW=AW+BW bits, signed), sign-extended to PW.
  - S3 updates the accumulator.
- Latency: a sample accepted at edge k updates pout at edge k+2.
  - With last=1, res/res_cnt/ovf load and res_valid=1 at that same edge k+2, for one cycle.
- in_valid=0: no update; pout, counter and sticky flag hold (bubbles allowed anywhere in a frame).
- Base value: base = sload ? 0 : acc.
  - new = base+p (00/11), base-p (01), or p-base (10).
  - Mode is per sample.
- Counter:
  - sload sets it to 1; otherwise increments per valid sample.
  - Saturates at 2^CNTW-1 (no wrap).
- Overflow:
  - Signed overflow of the PW-bit add/subtract sets a sticky flag.
  - sload clears it before evaluating its own sample.
- First valid sample after reset without sload accumulates onto 0, since acc=0 after reset.
- sload and last on the same sample: single-sample frame; res = ±p per mode (mode 10 gives p), res_cnt=1.
- Back-to-back frames: last followed immediately by sload at full rate; no dead cycle.
- last without a following sload: accumulator continues from the emitted value on the next sample.
- res/res_cnt/ovf only change on res_valid.

Optional Feature:
MAC_ACC_SAT_EN
- Defined: on overflow the accumulator clamps to the signed PW-bit max (positive overflow) or min (negative overflow); ovf still set.
- Undefined: two's-complement wrap; ovf still set.
- Applies to pout and res identically.

Test Plan:
1. Mode 00, in_valid every cycle: sload (2,3); (-4,5); last (7,1).
   - Expect res=-7, res_cnt=3.
   - res_valid is a single pulse 2 edges after the last sample.
2. Test 1 with 2-cycle in_valid gaps between samples.
   - Same res=-7, res_cnt=3.
   - pout constant during gaps.
3. Mode 01: sload mode00 (10,10), then mode01 last (1,1) → res=99.
   - Next frame: sload (1,5), then mode10 last (1,2) → res=-3.
4. sload+last together (-3,3) → res=-9, res_cnt=1.
   - Next cycle, sload+last (4,4) → res=16.
   - Two res_valid pulses on consecutive cycles.
5. AW=4, BW=4, PW=8: sload (7,7), (7,7), last (7,7) → ovf=1.
   - Default build: res=-109.
   - With MAC_ACC_SAT_EN: res=127.
   - Next frame sload (1,1) last → res=1, ovf=0.
6. Sample sload (5,5) accepted, rst_n=0 for 1 cycle, then idle.
   - No res_valid; pout=0 and res=0 after reset.
   - Then last-only (2,2) → res=4, res_cnt=1.
